msx2_ram_arbiter: RTL and testbench
===================================

// Module: msx2_ram_arbiter
// PURPOSE
//   Shares the single external RAM port behind the MSX2 memory mapper between the
//   CPU, which accesses through mapper segment registers, and one auxiliary
//   requester (ioctl loader/DMA). Builds the physical CPU address from the mapper
//   segment and runs a req/ack handshake on every side. Optional periodic refresh.
// PARAMETERS
//   SEG_BITS       8    segment bits used; ADDR_W = SEG_BITS+14
//   STARVE_LIMIT   4    consecutive CPU grants with aux pending before aux is forced
//   TIMEOUT        255  cycles to wait for ram_ack before abort (8-bit counter)
//   REFRESH_PERIOD 512  cycles between refresh requests (only with MSX2_RAM_REFRESH_EN)
// PORTS
//   clk          in   1       system clock
//   reset_n      in   1       asynchronous reset, active low
//   cpu_req      in   1       CPU access request, level, held until cpu_ack
//   cpu_wr       in   1       1=write, 0=read
//   cpu_addr     in   16      Z80 address; [13:0] offset in the segment
//   cpu_segment  in   8       mapper segment for cpu_addr[15:14]; bits >= SEG_BITS ignored
//   cpu_din      in   8       CPU write data
//   cpu_ack      out  1       one-cycle pulse: access complete
//   cpu_dout     out  8       read data, valid with cpu_ack, held until next ack
//   aux_req/aux_wr in 1       aux request (level) / direction
//   aux_addr     in   ADDR_W  aux physical address
//   aux_din      in   8       aux write data
//   aux_ack      out  1       one-cycle completion pulse
//   aux_dout     out  8       aux read data, valid with aux_ack
//   ram_req      out  1       RAM request, held until ram_ack
//   ram_wr       out  1       RAM direction
//   ram_addr     out  ADDR_W  RAM physical address
//   ram_din      out  8       RAM write data
//   ram_dout     in   8       RAM read data, valid with ram_ack
//   ram_ack      in   1       one-cycle pulse from RAM
//   ram_refresh  out  1       refresh request, held until ram_ack; 0 without macro
//   timeout_err  out  1       sticky: a timeout occurred; cleared by reset only
// BEHAVIOUR
//   Reset: state IDLE; ram_req, ram_wr, ram_refresh, cpu_ack, aux_ack, timeout_err = 0;
//     ram_addr, ram_din = 0; cpu_dout, aux_dout = 8'hFF; counters = 0. Async reset
//     mid-access drops ram_req at once; the in-flight access is lost, no ack is issued.
//   FSM: IDLE -> GNT_CPU | GNT_AUX | REFRESH; each returns to IDLE on ram_ack or timeout.
//   IDLE decision, in priority order:
//     1 refresh pending -> REFRESH
//     2 aux_req && starve_cnt == STARVE_LIMIT -> GNT_AUX
//     3 cpu_req -> GNT_CPU
//     4 aux_req -> GNT_AUX
//   No grant to a requester in the cycle its ack is issued, or in the cycle after
//     (requester drops req in the cycle after ack).
//   Grant: ram_addr/ram_wr/ram_din registered in the grant edge; ram_req high from
//     cycle N+1 when req was sampled in IDLE at cycle N.
//     CPU address = {cpu_segment[SEG_BITS-1:0], cpu_addr[13:0]}.
//   Completion: ram_ack at cycle M -> ram_req low at M+1; requester ack pulses at M+1
//     with dout = ram_dout captured at M (reads); write dout unchanged; state IDLE at M+1.
//   Timeout: wait counter clears on grant, increments each cycle with ram_req high;
//     reaching TIMEOUT -> ram_req low, ack pulse with dout = 8'hFF, timeout_err = 1.
//     A ram_ack arriving in IDLE is ignored.
//   Starvation: starve_cnt increments on each CPU grant while aux_req = 1, saturates
//     at STARVE_LIMIT, clears on aux grant or whenever aux_req = 0 in IDLE.
// CONFIGURATION
//   MSX2_RAM_REFRESH_EN defined: free-running counter sets refresh pending every
//     REFRESH_PERIOD cycles; pending clears on REFRESH entry. A second period elapsing
//     while pending does not queue a second refresh. REFRESH drives ram_refresh = 1,
//     ram_req = 0, and awaits ram_ack (timeout rules apply, no requester ack).
//   Not defined: no counter, no REFRESH state, ram_refresh tied 0.
// TESTING
//   CPU read, segment 8'h05, addr 16'h8123, ram_dout 8'h5A, ack after 3 cycles ->
//     ram_addr 22'h014123, cpu_ack 1 cycle after ram_ack, cpu_dout 8'h5A.
//   cpu_req and aux_req in the same IDLE cycle -> CPU granted first, aux next.
//   CPU re-requests continuously with aux_req held -> after 4 CPU grants aux gets
//     grant 5.
//   ram_ack never returned -> ack pulse after 255 cycles, cpu_dout 8'hFF,
//     timeout_err = 1 until reset.
//   reset_n low during GNT_AUX with ram_req high -> ram_req 0 at once, no aux_ack,
//     aux_dout 8'hFF.
//   MSX2_RAM_REFRESH_EN, period 512, continuous CPU traffic -> one ram_refresh per
//     512 cycles, no CPU grant lost.

Source files
------------

// File: rtl/msx2_ram_arbiter_if.sv
// Bus bundle between the MSX2 RAM arbiter, its CPU/aux requesters and the external RAM.
// slave is the arbiter's view; master is the environment (requesters plus RAM) view.
interface msx2_ram_arbiter_if #(
  parameter int SEG_BITS = 8
);
  localparam int ADDR_W = SEG_BITS + 14;

  logic              cpu_req;
  logic              cpu_wr;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_segment;
  logic [7:0]        cpu_din;
  logic              cpu_ack;
  logic [7:0]        cpu_dout;

  logic              aux_req;
  logic              aux_wr;
  logic [ADDR_W-1:0] aux_addr;
  logic [7:0]        aux_din;
  logic              aux_ack;
  logic [7:0]        aux_dout;

  logic              ram_req;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic              ram_ack;
  logic              ram_refresh;

  logic              timeout_err;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_segment, cpu_din,
    output cpu_ack, cpu_dout,
    input  aux_req, aux_wr, aux_addr, aux_din,
    output aux_ack, aux_dout,
    output ram_req, ram_wr, ram_addr, ram_din, ram_refresh,
    input  ram_dout, ram_ack,
    output timeout_err
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_segment, cpu_din,
    input  cpu_ack, cpu_dout,
    output aux_req, aux_wr, aux_addr, aux_din,
    input  aux_ack, aux_dout,
    input  ram_req, ram_wr, ram_addr, ram_din, ram_refresh,
    output ram_dout, ram_ack,
    input  timeout_err
  );
endinterface

// File: rtl/msx2_ram_arbiter.sv
// MSX2 RAM arbiter: shares one external RAM port between the mapper-addressed CPU and an aux requester.
// Optional periodic refresh is compiled in when MSX2_RAM_REFRESH_EN is defined.
module msx2_ram_arbiter #(
  parameter int SEG_BITS       = 8,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT        = 255,
  parameter int REFRESH_PERIOD = 512
) (
  input logic               clk,
  input logic               reset_n,
  msx2_ram_arbiter_if.slave bus
);
  localparam int ADDR_W   = SEG_BITS + 14;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

`ifdef MSX2_RAM_REFRESH_EN
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_AUX, REFRESH} state_t;
`else
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_AUX} state_t;
`endif

  state_t              state, state_next;
  logic                ram_req_q, ram_req_d;
  logic                ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                aux_ack_q, aux_ack_d;
  logic                ack_dly_q, ack_dly_d;
  logic [7:0]          cpu_dout_q, cpu_dout_d;
  logic [7:0]          aux_dout_q, aux_dout_d;
  logic                timeout_err_q, timeout_err_d;
  logic [7:0]          wait_q, wait_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                holdoff;
  logic                refresh_due;
  logic                wait_expired;
  logic [ADDR_W-1:0]   cpu_phys;
  logic                unused_inputs;

  assign cpu_phys      = {bus.cpu_segment[SEG_BITS-1:0], bus.cpu_addr[13:0]};
  assign unused_inputs = ^{bus.cpu_addr[15:14], bus.cpu_segment};
  // Requesters keep req high through their ack cycle and the one after, so nobody is granted then.
  assign holdoff       = cpu_ack_q | aux_ack_q | ack_dly_q;
  assign wait_expired  = (wait_q == 8'(TIMEOUT - 1));

`ifdef MSX2_RAM_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_PERIOD);

  logic [REF_W-1:0] refresh_cnt;
  logic             refresh_pending;
  logic             refresh_take;
  logic             refresh_q, refresh_d;

  // A period ending while a refresh is already pending does not queue another one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (refresh_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
        refresh_cnt     <= '0;
        refresh_pending <= 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + REF_W'(1);
        if (refresh_take) begin
          refresh_pending <= 1'b0;
        end
      end
    end
  end

  assign refresh_due     = refresh_pending;
  assign bus.ram_refresh = refresh_q;
`else
  assign refresh_due     = 1'b0;
  assign bus.ram_refresh = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    ram_req_d     = ram_req_q;
    ram_wr_d      = ram_wr_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    cpu_ack_d     = 1'b0;
    aux_ack_d     = 1'b0;
    ack_dly_d     = cpu_ack_q | aux_ack_q;
    cpu_dout_d    = cpu_dout_q;
    aux_dout_d    = aux_dout_q;
    timeout_err_d = timeout_err_q;
    wait_d        = wait_q;
    starve_d      = starve_q;
`ifdef MSX2_RAM_REFRESH_EN
    refresh_take  = 1'b0;
    refresh_d     = refresh_q;
`endif

    case (state)
      IDLE: begin
        if (!bus.aux_req) begin
          starve_d = '0;
        end
        if (refresh_due) begin
`ifdef MSX2_RAM_REFRESH_EN
          state_next   = REFRESH;
          refresh_d    = 1'b1;
          refresh_take = 1'b1;
          wait_d       = '0;
`endif
        end else if (!holdoff) begin
          if (bus.aux_req && (starve_q == STARVE_W'(STARVE_LIMIT))) begin
            state_next = GNT_AUX;
            ram_req_d  = 1'b1;
            ram_wr_d   = bus.aux_wr;
            ram_addr_d = bus.aux_addr;
            ram_din_d  = bus.aux_din;
            wait_d     = '0;
            starve_d   = '0;
          end else if (bus.cpu_req) begin
            state_next = GNT_CPU;
            ram_req_d  = 1'b1;
            ram_wr_d   = bus.cpu_wr;
            ram_addr_d = cpu_phys;
            ram_din_d  = bus.cpu_din;
            wait_d     = '0;
            if (bus.aux_req) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end else if (bus.aux_req) begin
            state_next = GNT_AUX;
            ram_req_d  = 1'b1;
            ram_wr_d   = bus.aux_wr;
            ram_addr_d = bus.aux_addr;
            ram_din_d  = bus.aux_din;
            wait_d     = '0;
            starve_d   = '0;
          end
        end
      end

      // A timed-out access completes like a normal one but returns 8'hFF and flags the error.
      GNT_CPU, GNT_AUX: begin
        if (bus.ram_ack || wait_expired) begin
          state_next = IDLE;
          ram_req_d  = 1'b0;
          if (state == GNT_CPU) begin
            cpu_ack_d = 1'b1;
          end else begin
            aux_ack_d = 1'b1;
          end
          if (!bus.ram_ack) begin
            timeout_err_d = 1'b1;
            if (state == GNT_CPU) begin
              cpu_dout_d = 8'hFF;
            end else begin
              aux_dout_d = 8'hFF;
            end
          end else if (!ram_wr_q) begin
            if (state == GNT_CPU) begin
              cpu_dout_d = bus.ram_dout;
            end else begin
              aux_dout_d = bus.ram_dout;
            end
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

`ifdef MSX2_RAM_REFRESH_EN
      REFRESH: begin
        if (bus.ram_ack || wait_expired) begin
          state_next = IDLE;
          refresh_d  = 1'b0;
          if (!bus.ram_ack) begin
            timeout_err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ram_req_q     <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= 8'h00;
      cpu_ack_q     <= 1'b0;
      aux_ack_q     <= 1'b0;
      ack_dly_q     <= 1'b0;
      cpu_dout_q    <= 8'hFF;
      aux_dout_q    <= 8'hFF;
      timeout_err_q <= 1'b0;
      wait_q        <= 8'h00;
      starve_q      <= '0;
`ifdef MSX2_RAM_REFRESH_EN
      refresh_q     <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      ram_req_q     <= ram_req_d;
      ram_wr_q      <= ram_wr_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      cpu_ack_q     <= cpu_ack_d;
      aux_ack_q     <= aux_ack_d;
      ack_dly_q     <= ack_dly_d;
      cpu_dout_q    <= cpu_dout_d;
      aux_dout_q    <= aux_dout_d;
      timeout_err_q <= timeout_err_d;
      wait_q        <= wait_d;
      starve_q      <= starve_d;
`ifdef MSX2_RAM_REFRESH_EN
      refresh_q     <= refresh_d;
`endif
    end
  end

  assign bus.ram_req     = ram_req_q;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.aux_ack     = aux_ack_q;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.aux_dout    = aux_dout_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_msx2_ram_arbiter.sv
// Directed bench for msx2_ram_arbiter: plays the CPU, the aux requester and the RAM.
// Expected values are hand-computed constants; refresh scenario only with MSX2_RAM_REFRESH_EN.
module tb_msx2_ram_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  msx2_ram_arbiter_if #(.SEG_BITS(8)) bus ();

  msx2_ram_arbiter #(
    .SEG_BITS(8), .STARVE_LIMIT(4), .TIMEOUT(255), .REFRESH_PERIOD(512)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_segment = 8'h00; bus.cpu_din = 8'h00;
    bus.aux_req = 1'b0; bus.aux_wr = 1'b0; bus.aux_addr = 22'h000000; bus.aux_din = 8'h00;
    bus.ram_ack = 1'b0; bus.ram_dout = 8'h00;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_ram_req(input int budget, output bit seen);
    seen = bus.ram_req;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = bus.ram_req;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_req: got %b want 0", bus.ram_req); end
    n_cmp++; if (bus.ram_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_wr: got %b want 0", bus.ram_wr); end
    n_cmp++; if (bus.ram_refresh !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_refresh: got %b want 0", bus.ram_refresh); end
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_ack: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (bus.aux_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_aux_ack: got %b want 0", bus.aux_ack); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    n_cmp++; if (bus.ram_addr !== 22'h000000) begin n_fail++; $display("[TB] FAIL reset_ram_addr: got %h want 000000", bus.ram_addr); end
    n_cmp++; if (bus.ram_din !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_ram_din: got %h want 00", bus.ram_din); end
    n_cmp++; if (bus.cpu_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_cpu_dout: got %h want ff", bus.cpu_dout); end
    n_cmp++; if (bus.aux_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_aux_dout: got %h want ff", bus.aux_dout); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_request: got %b want 0", bus.ram_req); end
  endtask

  task automatic test_cpu_read();
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_segment = 8'h05; bus.cpu_addr = 16'h8123;
    tick();
    n_cmp++; if (bus.ram_req !== 1'b1) begin n_fail++; $display("[TB] FAIL cpu_read_req: got %b want 1", bus.ram_req); end
    n_cmp++; if (bus.ram_addr !== 22'h014123) begin n_fail++; $display("[TB] FAIL cpu_read_addr: got %h want 014123", bus.ram_addr); end
    n_cmp++; if (bus.ram_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read_wr: got %b want 0", bus.ram_wr); end
    repeat (2) tick();
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h5A;
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read_early_ack: got %b want 0", bus.cpu_ack); end
    tick();
    bus.ram_ack = 1'b0; bus.ram_dout = 8'h00;
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL cpu_read_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_dout !== 8'h5A) begin n_fail++; $display("[TB] FAIL cpu_read_dout: got %h want 5a", bus.cpu_dout); end
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read_req_drop: got %b want 0", bus.ram_req); end
    tick();
    bus.cpu_req = 1'b0;
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read_ack_pulse: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read_no_regrant: got %b want 0", bus.ram_req); end
    n_cmp++; if (bus.cpu_dout !== 8'h5A) begin n_fail++; $display("[TB] FAIL cpu_read_dout_hold: got %h want 5a", bus.cpu_dout); end
  endtask

  task automatic test_cpu_write();
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_segment = 8'h3C; bus.cpu_addr = 16'h4567; bus.cpu_din = 8'hA5;
    tick();
    n_cmp++; if (bus.ram_wr !== 1'b1) begin n_fail++; $display("[TB] FAIL cpu_write_wr: got %b want 1", bus.ram_wr); end
    n_cmp++; if (bus.ram_addr !== 22'h0F0567) begin n_fail++; $display("[TB] FAIL cpu_write_addr: got %h want 0f0567", bus.ram_addr); end
    n_cmp++; if (bus.ram_din !== 8'hA5) begin n_fail++; $display("[TB] FAIL cpu_write_din: got %h want a5", bus.ram_din); end
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h11;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL cpu_write_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL cpu_write_dout_kept: got %h want ff", bus.cpu_dout); end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_aux_read();
    do_reset();
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 22'h2ABCDE;
    tick();
    n_cmp++; if (bus.ram_req !== 1'b1) begin n_fail++; $display("[TB] FAIL aux_read_req: got %b want 1", bus.ram_req); end
    n_cmp++; if (bus.ram_addr !== 22'h2ABCDE) begin n_fail++; $display("[TB] FAIL aux_read_addr: got %h want 2abcde", bus.ram_addr); end
    bus.ram_ack = 1'b1; bus.ram_dout = 8'hC3;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.aux_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL aux_read_ack: got %b want 1", bus.aux_ack); end
    n_cmp++; if (bus.aux_dout !== 8'hC3) begin n_fail++; $display("[TB] FAIL aux_read_dout: got %h want c3", bus.aux_dout); end
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL aux_read_cpu_ack: got %b want 0", bus.cpu_ack); end
    tick();
    bus.aux_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit seen;
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_segment = 8'h01; bus.cpu_addr = 16'h0010;
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 22'h155555;
    tick();
    n_cmp++; if (bus.ram_addr !== 22'h004010) begin n_fail++; $display("[TB] FAIL simul_cpu_first: got %h want 004010", bus.ram_addr); end
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h77;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_cpu_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_dout !== 8'h77) begin n_fail++; $display("[TB] FAIL simul_cpu_dout: got %h want 77", bus.cpu_dout); end
    tick();
    bus.cpu_req = 1'b0;
    wait_ram_req(10, seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_aux_grant: got %b want 1", seen); end
    n_cmp++; if (bus.ram_addr !== 22'h155555) begin n_fail++; $display("[TB] FAIL simul_aux_addr: got %h want 155555", bus.ram_addr); end
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h99;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.aux_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_aux_ack: got %b want 1", bus.aux_ack); end
    n_cmp++; if (bus.aux_dout !== 8'h99) begin n_fail++; $display("[TB] FAIL simul_aux_dout: got %h want 99", bus.aux_dout); end
    tick();
    bus.aux_req = 1'b0;
  endtask

  task automatic test_starvation();
    bit          seen;
    logic [21:0] exp_addr;
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_segment = 8'h02; bus.cpu_addr = 16'h0100;
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 22'h3FFFFF;
    for (int g = 1; g <= 5; g++) begin
      wait_ram_req(10, seen);
      n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_grant%0d_seen: got %b want 1", g, seen); end
      exp_addr = (g <= 4) ? 22'h008100 : 22'h3FFFFF;
      n_cmp++; if (bus.ram_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL starve_grant%0d_addr: got %h want %h", g, bus.ram_addr, exp_addr); end
      bus.ram_ack = 1'b1; bus.ram_dout = 8'(g);
      tick();
      bus.ram_ack = 1'b0;
      if (g == 5) begin
        n_cmp++; if (bus.aux_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_aux_ack: got %b want 1", bus.aux_ack); end
      end else begin
        n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_cpu_ack%0d: got %b want 1", g, bus.cpu_ack); end
      end
    end
    bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    int cnt;
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_segment = 8'h11; bus.cpu_addr = 16'h0001;
    tick();
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h42;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.cpu_dout !== 8'h42) begin n_fail++; $display("[TB] FAIL timeout_pre_dout: got %h want 42", bus.cpu_dout); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_pre_err: got %b want 0", bus.timeout_err); end
    tick();
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    bus.cpu_req = 1'b1;
    wait_ram_req(10, seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_grant: got %b want 1", seen); end
    cnt = 0;
    while (bus.ram_req && cnt < 300) begin
      cnt++;
      tick();
    end
    n_cmp++; if (cnt !== 255) begin n_fail++; $display("[TB] FAIL timeout_req_cycles: got %0d want 255", cnt); end
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL timeout_dout: got %h want ff", bus.cpu_dout); end
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err_set: got %b want 1", bus.timeout_err); end
    tick();
    bus.cpu_req = 1'b0;
    repeat (3) tick();
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h33;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err_sticky: got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ack_ignored: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL idle_ack_dout: got %h want ff", bus.cpu_dout); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_err_reset: got %b want 0", bus.timeout_err); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    bit ack_seen;
    do_reset();
    bus.aux_req = 1'b1; bus.aux_wr = 1'b0; bus.aux_addr = 22'h000123;
    tick();
    bus.ram_ack = 1'b1; bus.ram_dout = 8'h6C;
    tick();
    bus.ram_ack = 1'b0;
    n_cmp++; if (bus.aux_dout !== 8'h6C) begin n_fail++; $display("[TB] FAIL midreset_pre_dout: got %h want 6c", bus.aux_dout); end
    tick();
    bus.aux_req = 1'b0;
    repeat (2) tick();
    bus.aux_req = 1'b1; bus.aux_addr = 22'h0ABCDE;
    wait_ram_req(10, seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_grant: got %b want 1", seen); end
    n_cmp++; if (bus.ram_addr !== 22'h0ABCDE) begin n_fail++; $display("[TB] FAIL midreset_addr: got %h want 0abcde", bus.ram_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_req_drop: got %b want 0", bus.ram_req); end
    bus.aux_req = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.aux_ack) ack_seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.aux_ack) ack_seen = 1'b1;
    end
    n_cmp++; if (ack_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_no_ack: got %b want 0", ack_seen); end
    n_cmp++; if (bus.aux_dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL midreset_dout: got %h want ff", bus.aux_dout); end
    n_cmp++; if (bus.ram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_stays_idle: got %b want 0", bus.ram_req); end
  endtask

`ifdef MSX2_RAM_REFRESH_EN
  task automatic test_refresh();
    int refreshes = 0;
    int grants    = 0;
    int acks      = 0;
    bit overlap   = 1'b0;
    bit prev_ref  = 1'b0;
    bit prev_req  = 1'b0;
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_segment = 8'h04; bus.cpu_addr = 16'h0000;
    for (int c = 0; c < 1210; c++) begin
      if (c == 1200) bus.cpu_req = 1'b0;
      if (bus.ram_refresh && !prev_ref) refreshes++;
      if (bus.ram_req && !prev_req) grants++;
      if (bus.cpu_ack) acks++;
      if (bus.ram_req && bus.ram_refresh) overlap = 1'b1;
      prev_ref = bus.ram_refresh;
      prev_req = bus.ram_req;
      bus.ram_ack = (bus.ram_req || bus.ram_refresh) && !bus.ram_ack;
      bus.ram_dout = 8'h3E;
      tick();
    end
    bus.ram_ack = 1'b0;
    n_cmp++; if (refreshes !== 2) begin n_fail++; $display("[TB] FAIL refresh_count: got %0d want 2", refreshes); end
    n_cmp++; if (acks !== grants) begin n_fail++; $display("[TB] FAIL refresh_cpu_acks: got %0d want %0d", acks, grants); end
    n_cmp++; if (grants <= 100) begin n_fail++; $display("[TB] FAIL refresh_cpu_traffic: got %0d grants want more than 100", grants); end
    n_cmp++; if (overlap !== 1'b0) begin n_fail++; $display("[TB] FAIL refresh_overlap: got %b want 0", overlap); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_aux_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid_access();
`ifdef MSX2_RAM_REFRESH_EN
    test_refresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
